// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch / register-ALU control sequencer
//
// Drives the datapath control strobes for instruction fetch and for
// three-register ALU instructions, plus register-file select strobes.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous reset, active low
//   ir         instruction register (op = ir[31:27], Ra/Rb/Rc below it)
//   mem_ready  memory read data valid this cycle
//   PCout, Zlowout, MDRout, Rout            bus drive enables
//   MARin, Zin, PCin, MDRin, IRin, Yin, Rin register load enables
//   IncPC      ALU computes bus + 1
//   Read       memory read request
//   Gra, Grb, Grc  register-file field selects
//   alu_op     ALU operation code (valid in T4 only)
//   run        high while sequencing, low in HALT and while clr is low
//   illegal    one-cycle pulse on an unsupported opcode

module control_sequencer #(
    parameter logic [4:0] ALU_LO  = 5'b00011,
    parameter logic [4:0] ALU_HI  = 5'b01010,
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       op_is_alu;
    logic       op_is_halt;

    assign opcode     = ir[31:27];
    assign op_is_alu  = (opcode >= ALU_LO) && (opcode <= ALU_HI);
    assign op_is_halt = (opcode == HALT_OP);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:   state <= S_T0;
                S_T0:    state <= S_T1;
                // Fetch stalls here until memory returns the word.
                S_T1:    state <= mem_ready ? S_T2 : S_T1;
                S_T2:    state <= S_T3;
                S_T3: begin
                    if (op_is_alu)       state <= S_T4;
                    else if (op_is_halt) state <= S_HALT;
                    else                 state <= S_T0;
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Outputs decode straight from the state register (plus mem_ready in T1
    // and the opcode in T3/T4), so an asynchronous clr drops every strobe
    // in the same instant the state falls back to RST.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        alu_op  = 5'd0;
        run     = 1'b0;
        illegal = 1'b0;
        case (state)
            // RST is also the state held while clr is low; run only rises
            // once clr has been released.
            S_RST: run = clr;
            S_T0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC+1 is committed only on the cycle the fetch completes,
                // so PCin fires once per fetch however long the stall.
                Zlowout = mem_ready;
                PCin    = mem_ready;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (op_is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (!op_is_halt) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                run    = 1'b1;
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = opcode;
            end
            S_T5: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            S_HALT: run = 1'b0;
            default: run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer

module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b0;

    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, run, illegal;
    logic [4:0] alu_op;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [22:0] act;
    assign act = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal};

    localparam logic [22:0] M_PCOUT   = 23'd1 << 22;
    localparam logic [22:0] M_ZLOWOUT = 23'd1 << 21;
    localparam logic [22:0] M_MDROUT  = 23'd1 << 20;
    localparam logic [22:0] M_MARIN   = 23'd1 << 19;
    localparam logic [22:0] M_ZIN     = 23'd1 << 18;
    localparam logic [22:0] M_PCIN    = 23'd1 << 17;
    localparam logic [22:0] M_MDRIN   = 23'd1 << 16;
    localparam logic [22:0] M_IRIN    = 23'd1 << 15;
    localparam logic [22:0] M_YIN     = 23'd1 << 14;
    localparam logic [22:0] M_INCPC   = 23'd1 << 13;
    localparam logic [22:0] M_READ    = 23'd1 << 12;
    localparam logic [22:0] M_GRA     = 23'd1 << 11;
    localparam logic [22:0] M_GRB     = 23'd1 << 10;
    localparam logic [22:0] M_GRC     = 23'd1 << 9;
    localparam logic [22:0] M_RIN     = 23'd1 << 8;
    localparam logic [22:0] M_ROUT    = 23'd1 << 7;
    localparam logic [22:0] M_RUN     = 23'd1 << 1;
    localparam logic [22:0] M_ILLEGAL = 23'd1;

    // Reference model: per-cycle expected strobe words and the mem_ready to apply.
    logic [22:0] exp_q[$];
    logic        mr_q[$];

    function automatic logic [22:0] op_field(input logic [4:0] op);
        return {16'd0, op, 2'b00};
    endfunction

    task automatic build(input logic [31:0] instr, input int stalls);
        logic [4:0] op;
        op = instr[31:27];
        exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        mr_q.push_back(1'($urandom));
        for (int s = 0; s < stalls; s++) begin
            exp_q.push_back(M_READ | M_MDRIN | M_RUN);
            mr_q.push_back(1'b0);
        end
        exp_q.push_back(M_READ | M_MDRIN | M_ZLOWOUT | M_PCIN | M_RUN);
        mr_q.push_back(1'b1);
        exp_q.push_back(M_MDROUT | M_IRIN | M_RUN);
        mr_q.push_back(1'($urandom));
        if (op >= 5'd3 && op <= 5'd10) begin
            exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
            exp_q.push_back(M_GRC | M_ROUT | M_ZIN | M_RUN | op_field(op));
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_RUN);
            repeat (3) mr_q.push_back(1'($urandom));
        end else if (op == 5'd27) begin
            exp_q.push_back(M_RUN);
            mr_q.push_back(1'($urandom));
        end else begin
            exp_q.push_back(M_RUN | M_ILLEGAL);
            mr_q.push_back(1'($urandom));
        end
    endtask

    // Applies n queued cycles (all when n < 0); entered and left just after a rising edge.
    task automatic play(input string name, input int n);
        int idx;
        logic [22:0] e;
        int bus, sel;
        idx = 0;
        while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
            e = exp_q.pop_front();
            mem_ready = mr_q.pop_front();
            @(negedge clk);
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: strobes got %h expected %h", name, idx, act, e);
            end
            bus = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(Rout);
            sel = int'(Gra) + int'(Grb) + int'(Grc);
            vectors++;
            if (bus > 1) begin
                miscompares++;
                $display("FAIL %s_bus_onehot cycle %0d: drivers got %0d expected <=1", name, idx, bus);
            end
            vectors++;
            if (sel > 1) begin
                miscompares++;
                $display("FAIL %s_sel_onehot cycle %0d: selects got %0d expected <=1", name, idx, sel);
            end
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    function automatic logic [4:0] rand_illegal_op();
        logic [4:0] op;
        op = 5'($urandom);
        while ((op >= 5'd3 && op <= 5'd10) || op == 5'd27) op = 5'($urandom);
        return op;
    endfunction

    task automatic test_reset();
        clr = 1'b1;
        #2 clr = 1'b0;
        ir = $urandom;
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (act !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_zero: got %h expected %h", act, 23'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (act !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", act, 23'd0);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        vectors++;
        if (act !== M_RUN) begin
            miscompares++;
            $display("FAIL reset_rst_state: got %h expected %h", act, M_RUN);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_basic();
        ir = 32'h28918000;
        build(ir, 0);
        play("alu_basic", -1);
    endtask

    task automatic test_stall();
        ir = 32'h28918000;
        build(ir, 3);
        play("alu_stall3", -1);
    endtask

    task automatic test_illegal();
        ir = {5'b11111, 27'($urandom)};
        build(ir, 0);
        play("illegal_11111", -1);
    endtask

    task automatic test_back_to_back();
        ir = {5'b00011, 27'($urandom)};
        build(ir, 0);
        play("b2b_first", -1);
        ir = {5'b01010, 27'($urandom)};
        build(ir, 0);
        play("b2b_second", -1);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) op = 5'($urandom_range(3, 10));
            else op = rand_illegal_op();
            ir = {op, 27'($urandom)};
            build(ir, int'($urandom_range(0, 3)));
            play($sformatf("random_%0d", i), -1);
        end
    endtask

    task automatic test_clr_mid();
        logic [22:0] e4;
        ir = {5'($urandom_range(3, 10)), 27'($urandom)};
        build(ir, int'($urandom_range(0, 2)));
        play("clr_mid_pre", exp_q.size() - 2);
        e4 = exp_q[0];
        exp_q.delete();
        mr_q.delete();
        mem_ready = 1'($urandom);
        @(negedge clk);
        vectors++;
        if (act !== e4 || Zin !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_mid_t4: got %h expected %h", act, e4);
        end
        #1 clr = 1'b0;
        #1;
        vectors++;
        if (act !== 23'd0) begin
            miscompares++;
            $display("FAIL clr_mid_async: got %h expected %h", act, 23'd0);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        vectors++;
        if (act !== M_RUN) begin
            miscompares++;
            $display("FAIL clr_mid_rst: got %h expected %h", act, M_RUN);
        end
        @(posedge clk); #1;
        build(ir, 0);
        play("clr_mid_restart", -1);
    endtask

    task automatic test_halt();
        ir = {5'b11011, 27'($urandom)};
        build(ir, int'($urandom_range(0, 2)));
        play("halt_entry", -1);
        for (int c = 0; c < 25; c++) begin
            ir = $urandom;
            mem_ready = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (act !== 23'd0) begin
                miscompares++;
                $display("FAIL halt_idle cycle %0d: got %h expected %h", c, act, 23'd0);
            end
            @(posedge clk); #1;
        end
        clr = 1'b0;
        #1;
        vectors++;
        if (act !== 23'd0) begin
            miscompares++;
            $display("FAIL halt_clr: got %h expected %h", act, 23'd0);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        vectors++;
        if (act !== M_RUN) begin
            miscompares++;
            $display("FAIL halt_exit_rst: got %h expected %h", act, M_RUN);
        end
        @(posedge clk); #1;
        ir = {5'($urandom_range(3, 10)), 27'($urandom)};
        build(ir, 1);
        play("halt_restart", -1);
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_random();
        test_clr_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
